// File: rtl/stopwatch_scan_driver.sv
// stopwatch_scan_driver: mm:ss stopwatch with 4-digit scan driver; define LEADING_ZERO_BLANK_EN to blank leading minute zeros
module stopwatch_scan_driver #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] digit,
    output logic [3:0] an,
    output logic       colon,
    output logic       running,
    output logic       wrap
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
    logic [3:0]    digit_q, digit_d, an_q, an_d;
    logic          colon_q, colon_d, running_q, running_d, wrap_q, wrap_d;
    logic          tick, c1, c2, c3, c4, scan_tc, blank2, blank3;

    always_comb begin
        tick      = state_q == RUN && pre_q == PRE_MAX;
        c1        = tick && s1_q == 4'd9;
        c2        = c1 && s10_q == 4'd5;
        c3        = c2 && m1_q == 4'd9;
        c4        = c3 && m10_q == 4'd5;
        state_d   = clear ? IDLE : start ? RUN : (stop && state_q == RUN) ? PAUSE : state_q;
        // resuming from PAUSE keeps the partial second already counted
        pre_d     = (clear || (start && state_q == IDLE)) ? '0 :
                    state_q != RUN ? pre_q : tick ? '0 : pre_q + 1'b1;
        s1_d      = clear ? 4'd0 : !tick ? s1_q : c1 ? 4'd0 : s1_q + 4'd1;
        s10_d     = clear ? 4'd0 : !c1 ? s10_q : c2 ? 4'd0 : s10_q + 4'd1;
        m1_d      = clear ? 4'd0 : !c2 ? m1_q : c3 ? 4'd0 : m1_q + 4'd1;
        m10_d     = clear ? 4'd0 : !c3 ? m10_q : c4 ? 4'd0 : m10_q + 4'd1;
        wrap_d    = !clear && c4;
        running_d = state_d == RUN;
        scan_tc   = scan_q == SCAN_MAX;
        scan_d    = scan_tc ? '0 : scan_q + 1'b1;
        idx_d     = idx_q + {1'b0, scan_tc};
`ifdef LEADING_ZERO_BLANK_EN
        blank3    = m10_q == 4'd0;
        blank2    = blank3 && m1_q == 4'd0;
`else
        blank3    = 1'b0;
        blank2    = 1'b0;
`endif
        digit_d   = idx_q == 2'd0 ? s1_q :
                    idx_q == 2'd1 ? s10_q :
                    idx_q == 2'd2 ? (blank2 ? 4'hF : m1_q) :
                    (blank3 ? 4'hF : m10_q);
        an_d      = ~(4'b0001 << idx_q);
        colon_d   = idx_q == 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            scan_q    <= '0;
            idx_q     <= 2'd0;
            s1_q      <= 4'd0;
            s10_q     <= 4'd0;
            m1_q      <= 4'd0;
            m10_q     <= 4'd0;
            digit_q   <= 4'd0;
            an_q      <= 4'b1110;
            colon_q   <= 1'b0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            s1_q      <= s1_d;
            s10_q     <= s10_d;
            m1_q      <= m1_d;
            m10_q     <= m10_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            colon_q   <= colon_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign digit   = digit_q;
    assign an      = an_q;
    assign colon   = colon_q;
    assign running = running_q;
    assign wrap    = wrap_q;
endmodule
